// File: rtl/tjmono_rx_arbiter.sv
// Round-robin merge of N TJ-Monopix RX word streams into one FIFO-style stream.
// A channel keeps the grant until its 11-tagged word passes or it starves past TIMEOUT.
module tjmono_rx_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            BUS_CLK,
    input  logic            BUS_RST_N,
    input  logic [N-1:0]    IN_ENABLE,
    input  logic [N-1:0]    IN_EMPTY,
    input  logic [32*N-1:0] IN_DATA,
    output logic [N-1:0]    IN_READ,
    input  logic            OUT_READ,
    output logic            OUT_EMPTY,
    output logic [31:0]     OUT_DATA,
    output logic [N-1:0]    GRANT,
    output logic            BUSY,
    input  logic            CLR_CNT,
    output logic [7:0]      SEQ_ERR_CNT,
    output logic [7:0]      TIMEOUT_CNT
);
    localparam int PW = $clog2(N);

    typedef enum logic {S_IDLE, S_PACKET} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt;
    logic [PW-1:0] r_gidx, w_gidx_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt;
    logic [1:0]    r_exp, w_exp_nxt;
    logic [15:0]   r_starve, w_starve_nxt, w_starve_inc;
    logic [1:0]    r_occ, w_occ_ar;
    logic [31:0]   r_buf0, r_buf1;
    logic [7:0]    r_seq_cnt, r_to_cnt;
    logic          w_seq_inc, w_to_inc;
    logic          w_space, w_pop, w_rd, w_found;
    logic [PW-1:0] w_sel, w_cidx;
    logic [31:0]   w_in [N];
    logic [31:0]   w_word;
    logic [1:0]    w_tag;

    for (genvar gi = 0; gi < N; gi++) begin : g_split
        assign w_in[gi] = IN_DATA[32*gi +: 32];
    end

    assign w_space      = (r_occ != 2'd2);
    assign w_word       = w_in[r_gidx];
    assign w_tag        = w_word[29:28];
    assign w_pop        = BUS_RST_N && (r_state == S_PACKET) && !IN_EMPTY[r_gidx] && w_space;
    assign w_rd         = OUT_READ && (r_occ != 2'd0);
    assign w_occ_ar     = r_occ - {1'b0, w_rd};
    assign w_starve_inc = r_starve + 16'd1;

    assign IN_READ     = w_pop ? r_grant : '0;
    assign OUT_EMPTY   = (r_occ == 2'd0);
    assign OUT_DATA    = r_buf0;
    assign GRANT       = r_grant;
    assign BUSY        = (r_state == S_PACKET);
    assign SEQ_ERR_CNT = r_seq_cnt;
    assign TIMEOUT_CNT = r_to_cnt;

    // Round-robin search starting just after the last released channel.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cidx  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cidx = PW'((int'(r_ptr) + k) % N);
            if (!w_found && IN_ENABLE[w_cidx] && !IN_EMPTY[w_cidx]) begin
                w_found = 1'b1;
                w_sel   = w_cidx;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gidx_nxt   = r_gidx;
        w_grant_nxt  = r_grant;
        w_exp_nxt    = r_exp;
        w_starve_nxt = r_starve;
        w_seq_inc    = 1'b0;
        w_to_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = S_PACKET;
                    w_gidx_nxt   = w_sel;
                    w_grant_nxt  = N'(1) << w_sel;
                    w_exp_nxt    = 2'b00;
                    w_starve_nxt = '0;
                end
            end
            S_PACKET: begin
                if (w_pop) begin
                    w_starve_nxt = '0;
                    w_seq_inc    = (w_tag != r_exp);
                    w_exp_nxt    = w_tag + 2'd1;
                    if (w_tag == 2'b11) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = r_gidx;
                        w_grant_nxt = '0;
                    end
                end else if (w_space && IN_EMPTY[r_gidx]) begin
                    // A full output buffer freezes the starve count.
                    w_starve_nxt = w_starve_inc;
                    if (w_starve_inc == 16'(TIMEOUT)) begin
                        w_state_nxt  = S_IDLE;
                        w_ptr_nxt    = r_gidx;
                        w_grant_nxt  = '0;
                        w_starve_nxt = '0;
                        w_to_inc     = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_state  <= S_IDLE;
            r_ptr    <= PW'(N-1);
            r_gidx   <= '0;
            r_grant  <= '0;
            r_exp    <= 2'b00;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gidx   <= w_gidx_nxt;
            r_grant  <= w_grant_nxt;
            r_exp    <= w_exp_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Two-entry buffer; the head sits in r_buf0 so a write into empty shows at once.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            if (w_rd) r_buf0 <= r_buf1;
            if (w_pop) begin
                if (w_occ_ar == 2'd0) r_buf0 <= w_word;
                else                  r_buf1 <= w_word;
            end
            r_occ <= w_occ_ar + {1'b0, w_pop};
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N || CLR_CNT) begin
            r_seq_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (w_seq_inc && r_seq_cnt != 8'hFF) r_seq_cnt <= r_seq_cnt + 8'd1;
            if (w_to_inc && r_to_cnt != 8'hFF)   r_to_cnt  <= r_to_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_tjmono_rx_arbiter.sv
// Directed bench for tjmono_rx_arbiter: bench-side channel FIFOs, output capture, per-scenario checks.
module tb_tjmono_rx_arbiter;
    localparam int N = 4;

    logic            BUS_CLK = 1'b0;
    logic            BUS_RST_N;
    logic [N-1:0]    IN_ENABLE;
    logic [N-1:0]    IN_EMPTY;
    logic [32*N-1:0] IN_DATA;
    logic [N-1:0]    IN_READ;
    logic            OUT_READ;
    logic            OUT_EMPTY;
    logic [31:0]     OUT_DATA;
    logic [N-1:0]    GRANT;
    logic            BUSY;
    logic            CLR_CNT;
    logic [7:0]      SEQ_ERR_CNT;
    logic [7:0]      TIMEOUT_CNT;

    tjmono_rx_arbiter #(.N(N), .TIMEOUT(10)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .IN_ENABLE(IN_ENABLE), .IN_EMPTY(IN_EMPTY),
        .IN_DATA(IN_DATA), .IN_READ(IN_READ), .OUT_READ(OUT_READ), .OUT_EMPTY(OUT_EMPTY),
        .OUT_DATA(OUT_DATA), .GRANT(GRANT), .BUSY(BUSY), .CLR_CNT(CLR_CNT),
        .SEQ_ERR_CNT(SEQ_ERR_CNT), .TIMEOUT_CNT(TIMEOUT_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    logic [31:0] mem [N][512];
    int          rdp [N];
    int          wrp [N];
    logic [31:0] outq [$];
    int          grant_log [$];
    int          pops;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [N-1:0] prev_grant;

    function automatic logic [31:0] mkw(int ch, int pkt, logic [1:0] tag);
        return {2'b00, tag, 4'h0, 4'(ch), 8'(pkt), 12'h5a5};
    endfunction

    task automatic drive_in();
        for (int i = 0; i < N; i++) begin
            IN_EMPTY[i] = (rdp[i] == wrp[i]);
            IN_DATA[32*i +: 32] = IN_EMPTY[i] ? 32'h0 : mem[i][rdp[i]];
        end
    endtask

    task automatic push(int ch, int pkt, logic [1:0] tag);
        mem[ch][wrp[ch]] = mkw(ch, pkt, tag);
        wrp[ch]++;
        drive_in();
    endtask

    // One clock: sample strobes before the edge, apply pops and log grants just after it.
    task automatic tick();
        logic [N-1:0] rd;
        #1;
        rd = IN_READ;
        if (OUT_READ && !OUT_EMPTY) outq.push_back(OUT_DATA);
        prev_grant = GRANT;
        @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < N; i++) if (rd[i]) rdp[i]++;
        pops += $countones(rd);
        drive_in();
        if (prev_grant == '0 && GRANT != '0)
            for (int i = 0; i < N; i++) if (GRANT[i]) grant_log.push_back(i);
    endtask

    task automatic do_reset();
        BUS_RST_N = 1'b0;
        OUT_READ  = 1'b0;
        CLR_CNT   = 1'b0;
        IN_ENABLE = '1;
        for (int i = 0; i < N; i++) begin rdp[i] = 0; wrp[i] = 0; end
        drive_in();
        tick();
        tick();
        outq.delete();
        grant_log.delete();
        pops = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int t = 0; t < 4; t++) push(0, 0, 2'(t));
        #1;
        n_cmp++; if (IN_READ !== 4'b0000) begin n_bad++; $display("FAIL reset_in_read: got %b want 0000", IN_READ); end
        n_cmp++; if (GRANT !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", GRANT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (OUT_EMPTY !== 1'b1) begin n_bad++; $display("FAIL reset_out_empty: got %b want 1", OUT_EMPTY); end
        n_cmp++; if (OUT_DATA !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", OUT_DATA); end
        n_cmp++; if (SEQ_ERR_CNT !== 8'd0 || TIMEOUT_CNT !== 8'd0) begin n_bad++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", SEQ_ERR_CNT, TIMEOUT_CNT); end
    endtask

    task automatic test_single_packet();
        OUT_READ  = 1'b1;
        BUS_RST_N = 1'b1;
        tick();
        n_cmp++; if (GRANT !== 4'b0001 || BUSY !== 1'b1) begin n_bad++;
            $display("FAIL single_grant: got %b busy %b want 0001 busy 1", GRANT, BUSY); end
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (IN_READ !== 4'b0001) begin n_bad++;
                $display("FAIL single_in_read[%0d]: got %b want 0001", k, IN_READ); end
            tick();
            if (k == 0) begin
                n_cmp++; if (OUT_EMPTY !== 1'b0 || OUT_DATA !== mkw(0, 0, 2'd0)) begin n_bad++;
                    $display("FAIL single_first_word: got %h empty %b want %h empty 0", OUT_DATA, OUT_EMPTY, mkw(0, 0, 2'd0)); end
            end
        end
        n_cmp++; if (BUSY !== 1'b0 || GRANT !== 4'b0000) begin n_bad++;
            $display("FAIL single_release: got busy %b grant %b want 0 0000", BUSY, GRANT); end
        tick();
        n_cmp++; if (outq.size() !== 4) begin n_bad++; $display("FAIL single_count: got %0d want 4", outq.size()); end
        for (int k = 0; k < 4 && k < outq.size(); k++) begin
            n_cmp++; if (outq[k] !== mkw(0, 0, 2'(k))) begin n_bad++;
                $display("FAIL single_word[%0d]: got %h want %h", k, outq[k], mkw(0, 0, 2'(k))); end
        end
        n_cmp++; if (SEQ_ERR_CNT !== 8'd0 || OUT_EMPTY !== 1'b1) begin n_bad++;
            $display("FAIL single_end: got seq %0d empty %b want 0 1", SEQ_ERR_CNT, OUT_EMPTY); end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < N; c++)
                for (int t = 0; t < 4; t++) push(c, p, 2'(t));
        OUT_READ  = 1'b1;
        BUS_RST_N = 1'b1;
        repeat (40) tick();
        n_cmp++; if (pops !== 32) begin n_bad++; $display("FAIL fair_pops_40cyc: got %0d want 32", pops); end
        n_cmp++; if (grant_log.size() !== 8) begin n_bad++; $display("FAIL fair_grants: got %0d want 8", grant_log.size()); end
        for (int j = 0; j < 8 && j < grant_log.size(); j++) begin
            n_cmp++; if (grant_log[j] !== j % 4) begin n_bad++;
                $display("FAIL fair_order[%0d]: got %0d want %0d", j, grant_log[j], j % 4); end
        end
        tick();
        n_cmp++; if (outq.size() !== 32) begin n_bad++; $display("FAIL fair_count: got %0d want 32", outq.size()); end
        for (int j = 0; j < 32 && j < outq.size(); j++) begin
            n_cmp++; if (outq[j] !== mkw((j / 4) % 4, j / 16, 2'(j % 4))) begin n_bad++;
                $display("FAIL fair_word[%0d]: got %h want %h", j, outq[j], mkw((j / 4) % 4, j / 16, 2'(j % 4))); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push(2, 0, 2'd0);
        push(2, 0, 2'd1);
        OUT_READ  = 1'b0;
        BUS_RST_N = 1'b1;
        repeat (16) tick();
        #1;
        n_cmp++; if (pops !== 2) begin n_bad++; $display("FAIL bp_pops: got %0d want 2", pops); end
        n_cmp++; if (IN_READ !== 4'b0000) begin n_bad++; $display("FAIL bp_in_read: got %b want 0000", IN_READ); end
        n_cmp++; if (GRANT !== 4'b0100 || BUSY !== 1'b1 || TIMEOUT_CNT !== 8'd0) begin n_bad++;
            $display("FAIL bp_hold: got grant %b busy %b to %0d want 0100 1 0", GRANT, BUSY, TIMEOUT_CNT); end
        n_cmp++; if (OUT_DATA !== mkw(2, 0, 2'd0)) begin n_bad++;
            $display("FAIL bp_head: got %h want %h", OUT_DATA, mkw(2, 0, 2'd0)); end
        push(2, 0, 2'd2);
        push(2, 0, 2'd3);
        OUT_READ = 1'b1;
        repeat (5) tick();
        n_cmp++; if (pops !== 4 || outq.size() !== 4) begin n_bad++;
            $display("FAIL bp_drain: got pops %0d out %0d want 4 4", pops, outq.size()); end
        for (int k = 0; k < 4 && k < outq.size(); k++) begin
            n_cmp++; if (outq[k] !== mkw(2, 0, 2'(k))) begin n_bad++;
                $display("FAIL bp_word[%0d]: got %h want %h", k, outq[k], mkw(2, 0, 2'(k))); end
        end
        n_cmp++; if (TIMEOUT_CNT !== 8'd0 || BUSY !== 1'b0 || OUT_EMPTY !== 1'b1) begin n_bad++;
            $display("FAIL bp_end: got to %0d busy %b empty %b want 0 0 1", TIMEOUT_CNT, BUSY, OUT_EMPTY); end
    endtask

    task automatic test_starvation();
        do_reset();
        push(1, 0, 2'd0);
        push(1, 0, 2'd1);
        for (int t = 0; t < 4; t++) push(3, 0, 2'(t));
        OUT_READ  = 1'b1;
        BUS_RST_N = 1'b1;
        repeat (12) tick();
        n_cmp++; if (GRANT !== 4'b0010 || TIMEOUT_CNT !== 8'd0) begin n_bad++;
            $display("FAIL starve_before: got grant %b to %0d want 0010 0", GRANT, TIMEOUT_CNT); end
        tick();
        n_cmp++; if (GRANT !== 4'b0000 || BUSY !== 1'b0) begin n_bad++;
            $display("FAIL starve_release: got grant %b busy %b want 0000 0", GRANT, BUSY); end
        n_cmp++; if (TIMEOUT_CNT !== 8'd1) begin n_bad++; $display("FAIL starve_to_cnt: got %0d want 1", TIMEOUT_CNT); end
        tick();
        n_cmp++; if (GRANT !== 4'b1000) begin n_bad++; $display("FAIL starve_next: got %b want 1000", GRANT); end
        repeat (5) tick();
        n_cmp++; if (outq.size() !== 6) begin n_bad++; $display("FAIL starve_count: got %0d want 6", outq.size()); end
        for (int k = 0; k < 6 && k < outq.size(); k++) begin
            n_cmp++; if (outq[k] !== (k < 2 ? mkw(1, 0, 2'(k)) : mkw(3, 0, 2'(k - 2)))) begin n_bad++;
                $display("FAIL starve_word[%0d]: got %h", k, outq[k]); end
        end
    endtask

    task automatic test_tag_error();
        do_reset();
        push(0, 5, 2'd0);
        push(0, 5, 2'd2);
        push(0, 5, 2'd3);
        OUT_READ  = 1'b1;
        BUS_RST_N = 1'b1;
        repeat (5) tick();
        n_cmp++; if (SEQ_ERR_CNT !== 8'd1) begin n_bad++; $display("FAIL tag_seq_cnt: got %0d want 1", SEQ_ERR_CNT); end
        n_cmp++; if (outq.size() !== 3) begin n_bad++; $display("FAIL tag_count: got %0d want 3", outq.size()); end
        n_cmp++; if (outq.size() == 3 && outq[1] !== mkw(0, 5, 2'd2)) begin n_bad++;
            $display("FAIL tag_forward: got %h want %h", outq[1], mkw(0, 5, 2'd2)); end
        n_cmp++; if (GRANT !== 4'b0000 || BUSY !== 1'b0) begin n_bad++;
            $display("FAIL tag_release: got grant %b busy %b want 0000 0", GRANT, BUSY); end
        CLR_CNT = 1'b1;
        tick();
        CLR_CNT = 1'b0;
        n_cmp++; if (SEQ_ERR_CNT !== 8'd0) begin n_bad++; $display("FAIL tag_clear: got %0d want 0", SEQ_ERR_CNT); end
        push(0, 6, 2'd0);
        push(0, 6, 2'd0);
        tick();
        tick();
        CLR_CNT = 1'b1;
        tick();
        CLR_CNT = 1'b0;
        n_cmp++; if (SEQ_ERR_CNT !== 8'd0) begin n_bad++;
            $display("FAIL tag_clear_priority: got %0d want 0", SEQ_ERR_CNT); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 262; k++) push(0, k, 2'd0);
        OUT_READ  = 1'b1;
        BUS_RST_N = 1'b1;
        repeat (264) tick();
        n_cmp++; if (SEQ_ERR_CNT !== 8'd255) begin n_bad++; $display("FAIL sat_seq_cnt: got %0d want 255", SEQ_ERR_CNT); end
        repeat (12) tick();
        n_cmp++; if (TIMEOUT_CNT !== 8'd1 || GRANT !== 4'b0000) begin n_bad++;
            $display("FAIL sat_timeout: got to %0d grant %b want 1 0000", TIMEOUT_CNT, GRANT); end
    endtask

    task automatic test_mask_reset();
        do_reset();
        IN_ENABLE = 4'b0101;
        for (int c = 0; c < 3; c++)
            for (int t = 0; t < 4; t++) push(c, 1, 2'(t));
        push(3, 1, 2'd1);
        push(3, 1, 2'd2);
        OUT_READ  = 1'b1;
        BUS_RST_N = 1'b1;
        repeat (10) tick();
        n_cmp++; if (grant_log.size() !== 2) begin n_bad++; $display("FAIL mask_grants: got %0d want 2", grant_log.size()); end
        n_cmp++; if (grant_log.size() == 2 && (grant_log[0] !== 0 || grant_log[1] !== 2)) begin n_bad++;
            $display("FAIL mask_order: got %0d,%0d want 0,2", grant_log[0], grant_log[1]); end
        repeat (3) tick();
        n_cmp++; if (GRANT !== 4'b0000 || pops !== 8) begin n_bad++;
            $display("FAIL mask_idle: got grant %b pops %0d want 0000 8", GRANT, pops); end
        OUT_READ  = 1'b0;
        IN_ENABLE = 4'b1111;
        tick();
        n_cmp++; if (GRANT !== 4'b1000) begin n_bad++; $display("FAIL mask_unmask: got %b want 1000", GRANT); end
        tick();
        n_cmp++; if (SEQ_ERR_CNT !== 8'd1 || OUT_EMPTY !== 1'b0 || BUSY !== 1'b1) begin n_bad++;
            $display("FAIL mid_state: got seq %0d empty %b busy %b want 1 0 1", SEQ_ERR_CNT, OUT_EMPTY, BUSY); end
        BUS_RST_N = 1'b0;
        #1;
        n_cmp++; if (IN_READ !== 4'b0000) begin n_bad++; $display("FAIL rst_in_read: got %b want 0000", IN_READ); end
        tick();
        n_cmp++; if (GRANT !== 4'b0000 || BUSY !== 1'b0 || OUT_EMPTY !== 1'b1) begin n_bad++;
            $display("FAIL rst_flush: got grant %b busy %b empty %b want 0000 0 1", GRANT, BUSY, OUT_EMPTY); end
        n_cmp++; if (SEQ_ERR_CNT !== 8'd0 || TIMEOUT_CNT !== 8'd0) begin n_bad++;
            $display("FAIL rst_counters: got %0d/%0d want 0/0", SEQ_ERR_CNT, TIMEOUT_CNT); end
    endtask

    initial begin
        BUS_RST_N = 1'b0;
        OUT_READ  = 1'b0;
        CLR_CNT   = 1'b0;
        IN_ENABLE = '1;
        IN_EMPTY  = '1;
        IN_DATA   = '0;
        pops      = 0;
        test_reset();
        test_single_packet();
        test_fairness();
        test_backpressure();
        test_starvation();
        test_tag_error();
        test_saturation();
        test_mask_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
